// File: rtl/param_countdown_timer_if.sv
// Control and display bundle of param_countdown_timer.
// The panel side (master) drives the request pulses; the timer (slave) drives the count and status.
interface param_countdown_timer_if #(
  parameter int MIN_W = 7
);
  // load/start/stop are single-cycle request pulses sampled on the rising clk edge.
  // There is no backpressure: every request is acted on or rejected on that edge.
  // done_pulse and load_err are one-cycle response strobes. All other outputs are levels.
  logic             load;
  logic [MIN_W-1:0] load_min;
  logic [5:0]       load_sec;
  logic             load_up;
  logic             start;
  logic             stop;
  logic [MIN_W-1:0] out_min;
  logic [5:0]       out_sec;
  logic             running;
  logic             done;
  logic             done_pulse;
  logic             load_err;
  logic [1:0]       state_dbg;

  modport master (
    output load, load_min, load_sec, load_up, start, stop,
    input  out_min, out_sec, running, done, done_pulse, load_err, state_dbg
  );

  modport slave (
    input  load, load_min, load_sec, load_up, start, stop,
    output out_min, out_sec, running, done, done_pulse, load_err, state_dbg
  );
endinterface

// File: rtl/param_countdown_timer.sv
// Parametrised min:sec up/down timer with prescaler, pause/resume and done strobe.
// Optional macro AUTO_RELOAD_EN: reload the loaded value on reaching terminal and keep running.
module param_countdown_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int MAX_MIN  = 99,
  parameter int MIN_W    = 7
) (
  input  logic clk,
  input  logic rst_n,
  param_countdown_timer_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [MIN_W-1:0] MAX_M      = MIN_W'(MAX_MIN);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

  state_t           state, state_n;
  logic [MIN_W-1:0] cnt_min, cnt_min_n, step_min;
  logic [5:0]       cnt_sec, cnt_sec_n, step_sec;
  logic [PW-1:0]    presc, presc_n;
  logic             mode_up, mode_up_n;
  logic             running_q, done_q, dp_q, dp_n, le_q, le_n;
  logic             load_ok, at_term, step_term;
`ifdef AUTO_RELOAD_EN
  logic [MIN_W-1:0] shd_min, shd_min_n;
  logic [5:0]       shd_sec, shd_sec_n;
`endif

  assign load_ok = (bus.load_sec <= 6'd59) && (bus.load_min <= MAX_M);
  assign at_term = mode_up ? (cnt_min == MAX_M && cnt_sec == 6'd59)
                           : (cnt_min == '0 && cnt_sec == 6'd0);

  always_comb begin
    step_min = cnt_min;
    step_sec = cnt_sec;
    if (mode_up) begin
      if (cnt_sec != 6'd59) step_sec = cnt_sec + 6'd1;
      else begin
        step_sec = 6'd0;
        step_min = cnt_min + MIN_W'(1);
      end
    end else begin
      if (cnt_sec != 6'd0) step_sec = cnt_sec - 6'd1;
      else begin
        step_sec = 6'd59;
        step_min = cnt_min - MIN_W'(1);
      end
    end
    step_term = mode_up ? (step_min == MAX_M && step_sec == 6'd59)
                        : (step_min == '0 && step_sec == 6'd0);
  end

  always_comb begin
    state_n   = state;
    cnt_min_n = cnt_min;
    cnt_sec_n = cnt_sec;
    presc_n   = presc;
    mode_up_n = mode_up;
    dp_n      = 1'b0;
    le_n      = 1'b0;
`ifdef AUTO_RELOAD_EN
    shd_min_n = shd_min;
    shd_sec_n = shd_sec;
`endif
    if (bus.load) begin
      if (load_ok) begin
        state_n   = IDLE;
        cnt_min_n = bus.load_min;
        cnt_sec_n = bus.load_sec;
        mode_up_n = bus.load_up;
        presc_n   = '0;
`ifdef AUTO_RELOAD_EN
        shd_min_n = bus.load_min;
        shd_sec_n = bus.load_sec;
`endif
      end else begin
        le_n = 1'b1;
      end
    end else if (bus.stop) begin
      // The stop cycle is still a RUN cycle; a due tick is deferred to the resume.
      if (state == RUN) begin
        state_n = PAUSE;
        if (presc != PRESC_LAST) presc_n = presc + PW'(1);
      end
    end else if (bus.start && (state == IDLE || state == PAUSE)) begin
      if (at_term) begin
        state_n = DONE;
        dp_n    = 1'b1;
      end else begin
        state_n = RUN;
      end
    end else if (state == RUN) begin
      if (presc == PRESC_LAST) begin
        presc_n = '0;
        if (!at_term) begin
          cnt_min_n = step_min;
          cnt_sec_n = step_sec;
          if (step_term) begin
            dp_n = 1'b1;
`ifdef AUTO_RELOAD_EN
            cnt_min_n = shd_min;
            cnt_sec_n = shd_sec;
`else
            state_n = DONE;
`endif
          end
        end
      end else begin
        presc_n = presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt_min   <= '0;
      cnt_sec   <= '0;
      presc     <= '0;
      mode_up   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      dp_q      <= 1'b0;
      le_q      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt_min   <= cnt_min_n;
      cnt_sec   <= cnt_sec_n;
      presc     <= presc_n;
      mode_up   <= mode_up_n;
      running_q <= (state_n == RUN);
      done_q    <= (state_n == DONE);
      dp_q      <= dp_n;
      le_q      <= le_n;
    end
  end

`ifdef AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_min <= '0;
      shd_sec <= '0;
    end else begin
      shd_min <= shd_min_n;
      shd_sec <= shd_sec_n;
    end
  end
`endif

  assign bus.out_min    = cnt_min;
  assign bus.out_sec    = cnt_sec;
  assign bus.running    = running_q;
  assign bus.done       = done_q;
  assign bus.done_pulse = dp_q;
  assign bus.load_err   = le_q;
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_param_countdown_timer.sv
// Bench for param_countdown_timer (TICK_DIV=4, MAX_MIN=99); strobes are checked by a scoreboard monitor.
module tb_param_countdown_timer;
  localparam int MIN_W = 7;
  localparam int W     = 1 + MIN_W + 6;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];

  param_countdown_timer_if #(.MIN_W(MIN_W)) bus ();

  param_countdown_timer #(.TICK_DIV(4), .MAX_MIN(99), .MIN_W(MIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // strobe record: {is_load_err, min, sec}
  function automatic logic [W-1:0] rec(input logic err, input int m, input int s);
    return {err, MIN_W'(m), 6'(s)};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && (bus.done_pulse || bus.load_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual=%0d required=none", {bus.load_err, bus.out_min, bus.out_sec});
      end else begin
        chk("strobe", 32'({bus.load_err, bus.out_min, bus.out_sec}), 32'(exp_q.pop_front()));
      end
    end
  end

  // drivers
  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int m, input int s, input logic up);
    @(negedge clk);
    bus.load = 1'b1; bus.load_min = MIN_W'(m); bus.load_sec = 6'(s); bus.load_up = up;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic do_ctl(input logic st, input logic sp);
    @(negedge clk);
    bus.start = st; bus.stop = sp;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
  endtask

  task automatic chk_count(input string name, input int m, input int s);
    chk(name, 32'({bus.out_min, bus.out_sec}), 32'({MIN_W'(m), 6'(s)}));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.load = 1'b0; bus.load_min = '0; bus.load_sec = '0; bus.load_up = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0;
    idle_cycles(3);
    chk("reset_count", 32'({bus.out_min, bus.out_sec}), 32'd0);
    chk("reset_flags", 32'({bus.running, bus.done, bus.done_pulse, bus.load_err}), 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // illegal loads leave count, mode and state alone
    do_load(4, 33, 1'b0);
    chk_count("load_4_33", 4, 33);
    exp_q.push_back(rec(1'b1, 4, 33));
    do_load(5, 60, 1'b1);
    chk_count("bad_sec_count", 4, 33);
    chk("bad_sec_state", 32'(bus.state_dbg), 32'd0);
    exp_q.push_back(rec(1'b1, 4, 33));
    do_load(100, 0, 1'b1);
    chk_count("bad_min_count", 4, 33);
    do_ctl(1'b1, 1'b0);
    idle_cycles(4);
    chk_count("mode_kept_down", 4, 32);

`ifndef AUTO_RELOAD_EN
    // 1:02 down to 0:00
    do_load(1, 2, 1'b0);
    chk("load_in_run_idle", 32'(bus.running), 32'd0);
    exp_q.push_back(rec(1'b0, 0, 0));
    do_ctl(1'b1, 1'b0);
    chk("run_level", 32'(bus.running), 32'd1);
    idle_cycles(11);
    chk_count("down_before_12", 1, 0);
    idle_cycles(1);
    chk_count("down_at_12", 0, 59);
    idle_cycles(235);
    chk("done_before_248", 32'(bus.done), 32'd0);
    idle_cycles(1);
    chk_count("down_at_248", 0, 0);
    chk("done_at_248", 32'({bus.done, bus.done_pulse, bus.running}), 32'b110);
    idle_cycles(1);
    chk("done_held", 32'({bus.done, bus.done_pulse}), 32'b10);
    do_ctl(1'b1, 1'b0);
    idle_cycles(3);
    chk("start_ignored_done", 32'({bus.done, bus.running}), 32'b10);
    chk_count("done_frozen", 0, 0);
`endif

    // pause keeps the partial second
    do_load(0, 10, 1'b0);
    do_ctl(1'b1, 1'b0);
    do_ctl(1'b0, 1'b1);
    chk("paused", 32'(bus.state_dbg), 32'd2);
    idle_cycles(20);
    chk_count("pause_hold", 0, 10);
    do_ctl(1'b1, 1'b0);
    idle_cycles(1);
    chk_count("resume_plus1", 0, 10);
    idle_cycles(1);
    chk_count("resume_plus2", 0, 9);

`ifndef AUTO_RELOAD_EN
    // 98:58 up to 99:59
    do_load(98, 58, 1'b1);
    exp_q.push_back(rec(1'b0, 99, 59));
    do_ctl(1'b1, 1'b0);
    idle_cycles(4);
    chk_count("up_at_4", 98, 59);
    idle_cycles(4);
    chk_count("up_at_8", 99, 0);
    idle_cycles(235);
    chk("up_not_done", 32'(bus.done), 32'd0);
    idle_cycles(1);
    chk_count("up_at_244", 99, 59);
    chk("up_done", 32'(bus.done), 32'd1);
    // start and stop together in RUN
    do_load(10, 0, 1'b1);
    do_ctl(1'b1, 1'b0);
    do_ctl(1'b1, 1'b1);
    chk("start_stop_pause", 32'({bus.state_dbg, bus.running}), 32'b100);
    do_ctl(1'b1, 1'b0);
    chk("resume_run", 32'(bus.running), 32'd1);
`endif

    // asynchronous reset mid-run
    do_load(3, 17, 1'b0);
    do_ctl(1'b1, 1'b0);
    idle_cycles(3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'({bus.out_min, bus.out_sec}), 32'd0);
    chk("async_rst_flags", 32'({bus.running, bus.done, bus.done_pulse, bus.load_err}), 32'd0);
    idle_cycles(2);
    rst_n = 1'b1;
    exp_q.push_back(rec(1'b0, 0, 0));
    do_ctl(1'b1, 1'b0);
    chk("start_after_rst_done", 32'({bus.done, bus.running}), 32'b10);

`ifdef AUTO_RELOAD_EN
    // periodic reload from 0:02
    do_load(0, 2, 1'b0);
    repeat (3) exp_q.push_back(rec(1'b0, 0, 2));
    do_ctl(1'b1, 1'b0);
    idle_cycles(7);
    chk_count("ar_before_reload", 0, 1);
    idle_cycles(1);
    chk_count("ar_reload", 0, 2);
    chk("ar_levels", 32'({bus.running, bus.done, bus.done_pulse}), 32'b101);
    idle_cycles(16);
    chk("ar_still_running", 32'({bus.running, bus.done}), 32'b10);
    do_load(0, 5, 1'b0);
`endif

    idle_cycles(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
